wu_fetch: RTL and testbench

Work-unit instruction fetch stage of the manager. It accepts a start address and a descriptor-word count from the manager control, then issues one read per cycle to `wu_memory` (address + read strobe), wrapping modulo memory depth. Reads are throttled by a back-pressure stall from `wu_decode`, and the stage drains the two-cycle memory pipeline before signalling completion.

---
 rtl/wu_fetch.sv | 127 ++++++++++++
 tb/tb_wu_fetch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/wu_fetch.sv
// Work-unit fetch stage: walks a descriptor range in WU memory one word per cycle,
// honours decode back-pressure and abort, then drains the 2-cycle memory pipe before done.
module wu_fetch #(
  parameter int unsigned WU_ADDR_W = 10,
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned LEN_W     = 11
) (
  input  logic                 clk,
  input  logic                 reset_poweron_n,
  input  logic                 mcntl__wuf__start,
  input  logic [WU_ADDR_W-1:0] mcntl__wuf__start_addr,
  input  logic [LEN_W-1:0]     mcntl__wuf__len,
  input  logic                 mcntl__wuf__abort,
  input  logic                 wud__wuf__stall,
  output logic [WU_ADDR_W-1:0] wuf__wum__addr,
  output logic                 wuf__wum__read,
  output logic                 wuf__mcntl__busy,
  output logic                 wuf__mcntl__done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_e;

  // Wrap is decided against the last legal word, so a non-power-of-two depth
  // never lets the pointer walk into unpopulated address space.
  localparam int unsigned            LAST_WORD = MEM_DEPTH - 1;
  localparam logic [WU_ADDR_W-1:0]   LAST_ADDR = WU_ADDR_W'(LAST_WORD);
  localparam logic [1:0]             DRAIN_CYCLES = 2'd2;

  state_e               state_q, state_d;
  logic [WU_ADDR_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]     rem_q, rem_d;
  logic [1:0]           drain_cnt_q, drain_cnt_d;
  logic                 first_q, first_d;
  logic [WU_ADDR_W-1:0] addr_q, addr_d;
  logic                 read_q, read_d;
  logic [WU_ADDR_W-1:0] ptr_inc;
  logic                 rem_zero;

  assign ptr_inc  = (ptr_q == LAST_ADDR) ? '0 : ptr_q + WU_ADDR_W'(1);
  assign rem_zero = (rem_q == '0);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    drain_cnt_d = drain_cnt_q;
    first_d     = 1'b0;
    addr_d      = addr_q;
    read_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mcntl__wuf__start) begin
          ptr_d   = mcntl__wuf__start_addr;
          rem_d   = mcntl__wuf__len;
          first_d = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        // The entry cycle never takes the empty exit: a zero-length request
        // spends the same two FETCH cycles as a one-word request, minus the read.
        if (mcntl__wuf__abort || (rem_zero && !first_q)) begin
          rem_d       = '0;
          drain_cnt_d = DRAIN_CYCLES;
          state_d     = S_DRAIN;
        end else if (!rem_zero && !wud__wuf__stall) begin
          read_d = 1'b1;
          addr_d = ptr_q;
          ptr_d  = ptr_inc;
          rem_d  = rem_q - LEN_W'(1);
        end
      end

      S_DRAIN: begin
        drain_cnt_d = drain_cnt_q - 2'd1;
        if (drain_cnt_q == 2'd1) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      drain_cnt_q <= '0;
      first_q     <= 1'b0;
      addr_q      <= '0;
      read_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      drain_cnt_q <= drain_cnt_d;
      first_q     <= first_d;
      addr_q      <= addr_d;
      read_q      <= read_d;
    end
  end

  assign wuf__wum__addr   = addr_q;
  assign wuf__wum__read   = read_q;
  assign wuf__mcntl__busy = (state_q != S_IDLE);
  assign wuf__mcntl__done = (state_q == S_DONE);

endmodule

// File: tb/tb_wu_fetch.sv
// Cycle-by-cycle vector bench for wu_fetch: a table of per-cycle inputs and expected
// outputs, followed by a hand-written mid-fetch reset sequence.
module tb_wu_fetch;

  localparam int AW    = 10;
  localparam int LW    = 11;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] len;
  logic          abort;
  logic          stall;
  logic [AW-1:0] addr;
  logic          read;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  wu_fetch #(
    .WU_ADDR_W(AW),
    .MEM_DEPTH(DEPTH),
    .LEN_W    (LW)
  ) dut (
    .clk                   (clk),
    .reset_poweron_n       (rst_n),
    .mcntl__wuf__start     (start),
    .mcntl__wuf__start_addr(start_addr),
    .mcntl__wuf__len       (len),
    .mcntl__wuf__abort     (abort),
    .wud__wuf__stall       (stall),
    .wuf__wum__addr        (addr),
    .wuf__wum__read        (read),
    .wuf__mcntl__busy      (busy),
    .wuf__mcntl__done      (done)
  );

  typedef struct {
    logic          start;
    logic [AW-1:0] saddr;
    logic [LW-1:0] len;
    logic          abort;
    logic          stall;
    logic          e_read;
    logic [AW-1:0] e_addr;
    logic          e_busy;
    logic          e_done;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic [AW-1:0] sa, input logic [LW-1:0] ln,
                     input logic ab, input logic sl, input logic er, input logic [AW-1:0] ea,
                     input logic eb, input logic ed);
    vec_t v;
    v.start = st; v.saddr = sa; v.len = ln; v.abort = ab; v.stall = sl;
    v.e_read = er; v.e_addr = ea; v.e_busy = eb; v.e_done = ed;
    vq.push_back(v);
  endtask

  // Leaves the bench 1 time unit after a rising edge: outputs are settled and
  // inputs driven here are stable well before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic er, input logic [AW-1:0] ea,
                           input logic eb, input logic ed);
    check({tag, " read"}, 32'(read), 32'(er));
    check({tag, " addr"}, 32'(addr), 32'(ea));
    check({tag, " busy"}, 32'(busy), 32'(eb));
    check({tag, " done"}, 32'(done), 32'(ed));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = '0; len = '0; abort = 1'b0; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 10'h000, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    //  start sa      len abort stall | read addr    busy done
    // Basic fetch 0x010 x4: reads r2..r5, done r8.
    add(1, 10'h010, 4,  0, 0,   0, 10'h000, 0, 0); // r0
    add(0, 10'h000, 0,  0, 0,   0, 10'h000, 1, 0);
    add(0, 10'h000, 0,  0, 0,   1, 10'h010, 1, 0);
    add(0, 10'h000, 0,  0, 0,   1, 10'h011, 1, 0);
    add(0, 10'h000, 0,  0, 0,   1, 10'h012, 1, 0);
    add(0, 10'h000, 0,  0, 0,   1, 10'h013, 1, 0); // r5 last read
    add(0, 10'h000, 0,  0, 0,   0, 10'h013, 1, 0);
    add(0, 10'h000, 0,  0, 0,   0, 10'h013, 1, 0);
    add(0, 10'h000, 0,  0, 0,   0, 10'h013, 1, 1); // r8 done
    // Wrap-around from 0x3FE.
    add(1, 10'h3FE, 4,  0, 0,   0, 10'h013, 0, 0); // r9
    add(0, 10'h000, 0,  0, 0,   0, 10'h013, 1, 0);
    add(0, 10'h000, 0,  0, 0,   1, 10'h3FE, 1, 0);
    add(0, 10'h000, 0,  0, 0,   1, 10'h3FF, 1, 0);
    add(0, 10'h000, 0,  0, 0,   1, 10'h000, 1, 0);
    add(0, 10'h000, 0,  0, 0,   1, 10'h001, 1, 0); // r14 last read
    add(0, 10'h000, 0,  0, 0,   0, 10'h001, 1, 0);
    add(0, 10'h000, 0,  0, 0,   0, 10'h001, 1, 0);
    add(0, 10'h000, 0,  0, 0,   0, 10'h001, 1, 1); // r17 done
    // Zero length at S=r18, extra starts while busy must be ignored; done at S+5.
    add(1, 10'h100, 0,  0, 0,   0, 10'h001, 0, 0); // r18
    add(1, 10'h200, 5,  0, 0,   0, 10'h001, 1, 0);
    add(1, 10'h200, 5,  0, 0,   0, 10'h001, 1, 0);
    add(1, 10'h200, 5,  0, 0,   0, 10'h001, 1, 0);
    add(1, 10'h200, 5,  0, 0,   0, 10'h001, 1, 0);
    add(1, 10'h200, 5,  0, 0,   0, 10'h001, 1, 1); // r23 done
    add(0, 10'h000, 0,  0, 0,   0, 10'h001, 0, 0);
    // Back-pressure: len 6, three stalled cycles, stall ignored once empty.
    add(1, 10'h020, 6,  0, 0,   0, 10'h001, 0, 0); // r25
    add(0, 10'h000, 0,  0, 0,   0, 10'h001, 1, 0);
    add(0, 10'h000, 0,  0, 0,   1, 10'h020, 1, 0);
    add(0, 10'h000, 0,  0, 0,   1, 10'h021, 1, 0);
    add(0, 10'h000, 0,  0, 1,   1, 10'h022, 1, 0);
    add(0, 10'h000, 0,  0, 1,   0, 10'h022, 1, 0);
    add(0, 10'h000, 0,  0, 1,   0, 10'h022, 1, 0);
    add(0, 10'h000, 0,  0, 0,   0, 10'h022, 1, 0);
    add(0, 10'h000, 0,  0, 0,   1, 10'h023, 1, 0);
    add(0, 10'h000, 0,  0, 0,   1, 10'h024, 1, 0);
    add(0, 10'h000, 0,  0, 1,   1, 10'h025, 1, 0); // r35 last read
    add(0, 10'h000, 0,  0, 1,   0, 10'h025, 1, 0);
    add(0, 10'h000, 0,  0, 0,   0, 10'h025, 1, 0);
    add(0, 10'h000, 0,  0, 0,   0, 10'h025, 1, 1); // r38 done
    // Abort together with stall after the 3rd read; abort elsewhere is ignored.
    add(1, 10'h040, 10, 0, 0,   0, 10'h025, 0, 0); // r39
    add(0, 10'h000, 0,  0, 0,   0, 10'h025, 1, 0);
    add(0, 10'h000, 0,  0, 0,   1, 10'h040, 1, 0);
    add(0, 10'h000, 0,  0, 0,   1, 10'h041, 1, 0);
    add(0, 10'h000, 0,  1, 1,   1, 10'h042, 1, 0); // r43 last read
    add(0, 10'h000, 0,  0, 0,   0, 10'h042, 1, 0);
    add(0, 10'h000, 0,  1, 0,   0, 10'h042, 1, 0);
    add(0, 10'h000, 0,  1, 0,   0, 10'h042, 1, 1); // r46 done
    add(0, 10'h000, 0,  1, 0,   0, 10'h042, 0, 0);
    add(0, 10'h000, 0,  0, 0,   0, 10'h042, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      check_all($sformatf("row%0d", i), vq[i].e_read, vq[i].e_addr, vq[i].e_busy, vq[i].e_done);
      start      = vq[i].start;
      start_addr = vq[i].saddr;
      len        = vq[i].len;
      abort      = vq[i].abort;
      stall      = vq[i].stall;
      tick();
    end

    // Reset asserted mid-fetch: outputs clear at once, no done afterwards.
    start = 1'b1; start_addr = 10'h0A0; len = 8; abort = 1'b0; stall = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("rst_pre read", 32'(read), 32'(1));
    check("rst_pre addr", 32'(addr), 32'(10'h0A1));
    #3;
    rst_n = 1'b0;
    #1;
    check_all("rst_async", 1'b0, 10'h000, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("rst_idle%0d busy", i), 32'(busy), 32'(0));
      check($sformatf("rst_idle%0d done", i), 32'(done), 32'(0));
      check($sformatf("rst_idle%0d read", i), 32'(read), 32'(0));
    end

    // Fresh start after reset fetches from its own address.
    start = 1'b1; start_addr = 10'h0C5; len = 2;
    tick();
    start = 1'b0;
    check_all("post S+1", 1'b0, 10'h000, 1'b1, 1'b0);
    tick();
    check_all("post S+2", 1'b1, 10'h0C5, 1'b1, 1'b0);
    tick();
    check_all("post S+3", 1'b1, 10'h0C6, 1'b1, 1'b0);
    tick();
    check_all("post S+4", 1'b0, 10'h0C6, 1'b1, 1'b0);
    tick();
    check_all("post S+5", 1'b0, 10'h0C6, 1'b1, 1'b0);
    tick();
    check_all("post S+6", 1'b0, 10'h0C6, 1'b1, 1'b1);
    tick();
    check_all("post S+7", 1'b0, 10'h0C6, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
